icb2apb_pready: RTL

Parametrised ICB-to-APB4 bridge, successor to the single-cycle ICB/APB bridge in the peripheral subsystem. It adds a proper SETUP/ACCESS phase sequence, PREADY wait states, PSLVERR propagation to the ICB error response, an optional access timeout, and a configurable-depth response buffer so that back-to-back transfers proceed without an idle cycle. It sits between the ICB peripheral crossbar port and one APB segment.

---
 rtl/icb2apb_pready_pkg.sv | 20 ++
 rtl/icb2apb_rsp_buf.sv | 73 +++++++
 rtl/icb2apb_pready.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/icb2apb_pready_pkg.sv
// rtl/icb2apb_pready_pkg.sv - shared state encoding and sizing helpers for the ICB-to-APB4 bridge
//
// Contents:
//   apb_state_e   - APB phase state encoding (IDLE/SETUP/ACCESS)
//   rsp_entry_w() - width of one response buffer entry: {err, rdata}

package icb2apb_pready_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_e;

    // One response entry carries the error flag above the read data.
    function automatic int rsp_entry_w(input int dw);
        return dw + 1;
    endfunction

endpackage

// File: rtl/icb2apb_rsp_buf.sv
// rtl/icb2apb_rsp_buf.sv - response FIFO for the ICB-to-APB4 bridge
//
// Ports:
//   clk, rst_n      - clock, asynchronous active-low reset
//   push, push_data - write one entry (dropped only if full and not popping)
//   pop             - remove the head entry (ignored when empty)
//   head            - head entry, forced to 0 while empty
//   empty           - no entries held
//   count           - number of entries held

module icb2apb_rsp_buf #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 65
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             head,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot, so a push into a full buffer is still taken.
    assign do_push = push & (~full | do_pop);
    assign head    = empty ? '0 : mem[rd_ptr];

    // Storage needs no reset: the head is masked while empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/icb2apb_pready.sv
// rtl/icb2apb_pready.sv - ICB-to-APB4 bridge with wait states, PSLVERR, timeout and response buffer
//
// Ports:
//   clk, rst                      - clock, asynchronous active-low reset
//   i_icb_cmd_*                   - ICB command channel (valid/ready, read, addr, wdata, wmask)
//   i_icb_rsp_*                   - ICB response channel (valid/ready, err, rdata)
//   apb_paddr/pwrite/pwdata/pstrb - registered APB request fields
//   apb_pselx/apb_penable         - APB phase controls
//   apb_prdata/pready/pslverr     - APB slave returns

module icb2apb_pready
    import icb2apb_pready_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 64,
    parameter int RSP_DP  = 2,
    parameter int TIMEOUT = 0
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            i_icb_cmd_valid,
    output logic            i_icb_cmd_ready,
    input  logic            i_icb_cmd_read,
    input  logic [AW-1:0]   i_icb_cmd_addr,
    input  logic [DW-1:0]   i_icb_cmd_wdata,
    input  logic [DW/8-1:0] i_icb_cmd_wmask,

    output logic            i_icb_rsp_valid,
    input  logic            i_icb_rsp_ready,
    output logic            i_icb_rsp_err,
    output logic [DW-1:0]   i_icb_rsp_rdata,

    output logic [AW-1:0]   apb_paddr,
    output logic            apb_pwrite,
    output logic            apb_pselx,
    output logic            apb_penable,
    output logic [DW-1:0]   apb_pwdata,
    output logic [DW/8-1:0] apb_pstrb,
    input  logic [DW-1:0]   apb_prdata,
    input  logic            apb_pready,
    input  logic            apb_pslverr
);

    localparam int EW = rsp_entry_w(DW);
    localparam int CW = $clog2(RSP_DP + 1);

    apb_state_e      state;
    logic            cmd_hs;
    logic            cmd_ready_c;
    logic            pready_done;
    logic            timeout_hit;
    logic            timeout_done;
    logic            access_done;
    logic            push_err;
    logic [DW-1:0]   push_rdata;
    logic [EW-1:0]   push_data;
    logic [EW-1:0]   head;
    logic            empty;
    logic [CW-1:0]   count;

    assign pready_done  = (state == ST_ACCESS) & apb_pready;
    assign timeout_done = (state == ST_ACCESS) & ~apb_pready & timeout_hit;
    assign access_done  = pready_done | timeout_done;

    // Timeout entries always report an error with zero data; PREADY wins if both coincide.
    assign push_err   = pready_done ? apb_pslverr : 1'b1;
    assign push_rdata = (pready_done & ~apb_pwrite & ~apb_pslverr) ? apb_prdata : '0;
    assign push_data  = {push_err, push_rdata};

    // The in-flight transfer owns one buffer slot, so while ACCESS is completing a new
    // command needs a second free slot; in IDLE one free slot is enough.
    always_comb begin
        cmd_ready_c = 1'b0;
        if (state == ST_IDLE) begin
            cmd_ready_c = (count < CW'(RSP_DP));
        end else if (access_done) begin
            cmd_ready_c = (count < CW'(RSP_DP - 1));
        end
    end

    assign i_icb_cmd_ready = rst & cmd_ready_c;
    assign cmd_hs          = i_icb_cmd_valid & i_icb_cmd_ready;

    generate
        if (TIMEOUT != 0) begin : g_timeout
            localparam int TW = $clog2(TIMEOUT + 1);
            logic [TW-1:0] to_cnt;

            assign timeout_hit = (to_cnt == TW'(TIMEOUT - 1));

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    to_cnt <= '0;
                end else if (state == ST_SETUP) begin
                    to_cnt <= '0;
                end else if ((state == ST_ACCESS) && !apb_pready && !timeout_hit) begin
                    to_cnt <= to_cnt + 1'b1;
                end
            end
        end else begin : g_no_timeout
            assign timeout_hit = 1'b0;
        end
    endgenerate

    // A handshake can only occur in IDLE or on an ACCESS completion, so it is handled
    // ahead of the per-state transitions and covers both the start and back-to-back cases.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            apb_paddr   <= '0;
            apb_pwrite  <= 1'b0;
            apb_pselx   <= 1'b0;
            apb_penable <= 1'b0;
            apb_pwdata  <= '0;
            apb_pstrb   <= '0;
        end else if (cmd_hs) begin
            apb_paddr   <= i_icb_cmd_addr;
            apb_pwrite  <= ~i_icb_cmd_read;
            apb_pwdata  <= i_icb_cmd_wdata;
            apb_pstrb   <= i_icb_cmd_read ? '0 : i_icb_cmd_wmask;
            apb_pselx   <= 1'b1;
            apb_penable <= 1'b0;
            state       <= ST_SETUP;
        end else begin
            case (state)
                ST_IDLE: begin
                    state <= ST_IDLE;
                end
                ST_SETUP: begin
                    apb_penable <= 1'b1;
                    state       <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (access_done) begin
                        apb_pselx   <= 1'b0;
                        apb_penable <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                default: begin
                    apb_pselx   <= 1'b0;
                    apb_penable <= 1'b0;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

    icb2apb_rsp_buf #(
        .DEPTH (RSP_DP),
        .WIDTH (EW)
    ) u_rsp_buf (
        .clk       (clk),
        .rst_n     (rst),
        .push      (access_done),
        .push_data (push_data),
        .pop       (i_icb_rsp_valid & i_icb_rsp_ready),
        .head      (head),
        .empty     (empty),
        .count     (count)
    );

    assign i_icb_rsp_valid = ~empty;
    assign i_icb_rsp_err   = head[EW-1];
    assign i_icb_rsp_rdata = head[DW-1:0];

endmodule
